// File: rtl/conversor_bcd_serial_rolhas.sv
// Binary-to-packed-BCD converter (double dabble), one bit per clock; optional BLANK_LEADING_ZEROS_EN.
// Latency: accept edge T, result/done valid in the cycle after edge T+WIDTH+1.
// Backpressure: none; start is only sampled in IDLE and ignored (not queued) while busy.
module conversor_bcd_serial_rolhas #(
    parameter int WIDTH  = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [WIDTH-1:0]       bin_sr;
    logic [4*DIGITS-1:0]    acc;
    logic [4*DIGITS-1:0]    acc_adj;
    logic [4*DIGITS-1:0]    bcd_fin;
    logic                   sticky;
    logic [CNT_W-1:0]       cnt;
    logic                   load;
    logic                   step;
    logic                   finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                step = 1'b1;
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Add-3 correction applied to every digit before the shift.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_fin = sticky ? {DIGITS{4'h9}} : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr <= '0;
            acc    <= '0;
            sticky <= 1'b0;
            cnt    <= '0;
            bcd    <= '0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                bin_sr <= bin;
                acc    <= '0;
                sticky <= 1'b0;
                cnt    <= '0;
            end else if (step) begin
                // A carry out of the top digit means the value no longer fits in DIGITS digits.
                acc    <= {acc_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]};
                bin_sr <= bin_sr << 1;
                sticky <= sticky | acc_adj[4*DIGITS-1];
                cnt    <= cnt + CNT_W'(1);
            end
            if (finish) begin
                bcd <= bcd_fin;
                ovf <= sticky;
            end
        end
    end

`ifdef BLANK_LEADING_ZEROS_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              zeros;

    // Walk from the most significant digit down; digit 0 is never blanked.
    always_comb begin
        blank_nxt = '0;
        zeros     = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zeros        = zeros & (acc[4*i +: 4] == 4'd0);
            blank_nxt[i] = zeros & ~sticky;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= '0;
        end else if (finish) begin
            blank <= blank_nxt;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_conversor_bcd_serial_rolhas.sv
// Bench for conversor_bcd_serial_rolhas: three instances (7b/2d, 16b/5d, 16b/4d) against an arithmetic model.
module tb_conversor_bcd_serial_rolhas;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a, busy_a, done_a, ovf_a;
    logic [6:0]  bin_a;
    logic [7:0]  bcd_a;
    logic [1:0]  blank_a;

    logic        start_b, busy_b, done_b, ovf_b;
    logic [15:0] bin_b;
    logic [19:0] bcd_b;
    logic [4:0]  blank_b;

    logic        start_c, busy_c, done_c, ovf_c;
    logic [15:0] bin_c;
    logic [15:0] bcd_c;
    logic [3:0]  blank_c;

    conversor_bcd_serial_rolhas #(.WIDTH(7), .DIGITS(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a), .busy(busy_a),
        .done(done_a), .bcd(bcd_a), .ovf(ovf_a), .blank(blank_a)
    );

    conversor_bcd_serial_rolhas #(.WIDTH(16), .DIGITS(5)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b), .busy(busy_b),
        .done(done_b), .bcd(bcd_b), .ovf(ovf_b), .blank(blank_b)
    );

    conversor_bcd_serial_rolhas #(.WIDTH(16), .DIGITS(4)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .bin(bin_c), .busy(busy_c),
        .done(done_c), .bcd(bcd_c), .ovf(ovf_c), .blank(blank_c)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: decimal digits by division, saturation when v >= 10^d.
    function automatic logic [63:0] ref_bcd(input longint v, input int d, output logic o,
                                            output logic [15:0] bl);
        longint      p;
        longint      t;
        longint      q;
        logic [63:0] r;
        p  = 1;
        r  = '0;
        bl = '0;
        for (int i = 0; i < d; i++) p = p * 10;
        o = (v >= p);
        if (o) begin
            for (int i = 0; i < d; i++) r[4*i +: 4] = 4'h9;
        end else begin
            t = v;
            for (int i = 0; i < d; i++) begin
                r[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
`ifdef BLANK_LEADING_ZEROS_EN
            for (int i = 1; i < d; i++) begin
                q = 1;
                for (int j = 0; j < i; j++) q = q * 10;
                bl[i] = (v < q);
            end
`else
            q = 0;
`endif
        end
        return r;
    endfunction

    function automatic int ndig(input int sel);
        return (sel == 0) ? 2 : ((sel == 1) ? 5 : 4);
    endfunction

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done_a : ((sel == 1) ? done_b : done_c);
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : ((sel == 1) ? busy_b : busy_c);
    endfunction

    function automatic logic get_ovf(input int sel);
        return (sel == 0) ? ovf_a : ((sel == 1) ? ovf_b : ovf_c);
    endfunction

    function automatic logic [63:0] get_bcd(input int sel);
        return (sel == 0) ? 64'(bcd_a) : ((sel == 1) ? 64'(bcd_b) : 64'(bcd_c));
    endfunction

    function automatic logic [15:0] get_blank(input int sel);
        return (sel == 0) ? 16'(blank_a) : ((sel == 1) ? 16'(blank_b) : 16'(blank_c));
    endfunction

    task automatic drive(input int sel, input logic s, input longint v);
        case (sel)
            0:       begin start_a = s; bin_a = v[6:0];  end
            1:       begin start_b = s; bin_b = v[15:0]; end
            default: begin start_c = s; bin_c = v[15:0]; end
        endcase
    endtask

    // Entered at a negedge; returns at the negedge of the cycle where done is high.
    task automatic convert(input int sel, input longint v, output logic [63:0] e_bcd);
        int          w;
        int          edges;
        logic        seen;
        logic        e_ovf;
        logic [15:0] e_blank;
        w     = (sel == 0) ? 7 : 16;
        e_bcd = ref_bcd(v, ndig(sel), e_ovf, e_blank);
        drive(sel, 1'b1, v);
        @(posedge clk);
        @(negedge clk);
        drive(sel, 1'b0, longint'($urandom));
        check("busy_after_accept", 64'(get_busy(sel)), 64'd1);
        check("done_low_in_conv", 64'(get_done(sel)), 64'd0);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < w + 8) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            seen = get_done(sel);
        end
        check("done_seen", 64'(seen), 64'd1);
        check("latency", 64'(edges), 64'(w + 1));
        check("bcd", get_bcd(sel), e_bcd);
        check("ovf", 64'(get_ovf(sel)), 64'(e_ovf));
        check("blank", 64'(get_blank(sel)), 64'(e_blank));
    endtask

    logic [63:0] e;
    logic [63:0] e_prev;
    logic        eo;
    logic [15:0] eb;
    int          n;
    longint      v;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        drive(2, 1'b0, 0);
        #1;
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check("rst_bcd", 64'(bcd_a), 64'd0);
        check("rst_ovf", 64'(ovf_a), 64'd0);
        check("rst_blank", 64'(blank_a), 64'd0);
        check("rst_bcd_b", 64'(bcd_b), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        convert(0, 57, e);
        @(negedge clk);
        check("busy_after_done", 64'(busy_a), 64'd0);
        check("done_single", 64'(done_a), 64'd0);
        check("bcd_hold", 64'(bcd_a), e);

        // Back-to-back at the earliest accept edge.
        convert(0, 0, e);
        convert(0, 99, e);
        convert(0, 100, e);
        convert(0, 127, e);
        convert(0, 10, e);

        // Second start during conversion is ignored.
        @(negedge clk);
        e = ref_bcd(83, 2, eo, eb);
        drive(0, 1'b1, 83);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 5);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 5);
        n = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) n++;
        end
        check("ignore_done_count", 64'(n), 64'd1);
        check("ignore_bcd", 64'(bcd_a), e);

        // Reset mid-conversion.
        convert(0, 77, e);
        @(negedge clk);
        drive(0, 1'b1, 40);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 0);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_bcd", 64'(bcd_a), 64'd0);
        check("abort_ovf", 64'(ovf_a), 64'd0);
        check("abort_busy", 64'(busy_a), 64'd0);
        check("abort_done", 64'(done_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (done_a) n++;
        end
        check("abort_no_done", 64'(n), 64'd0);
        convert(0, 12, e);

        // Random values with idle gaps; result must hold while idle.
        for (int k = 0; k < 24; k++) begin
            v = longint'($urandom_range(0, 127));
            convert(0, v, e);
            e_prev = e;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                drive(0, 1'b0, longint'($urandom));
                check("idle_hold_a", 64'(bcd_a), e_prev);
                check("idle_done_a", 64'(done_a), 64'd0);
            end
        end

        @(negedge clk);
        convert(1, 65535, e);
        convert(1, 0, e);
        convert(1, 9999, e);
        convert(1, 100, e);
        for (int k = 0; k < 6; k++) begin
            v = longint'($urandom_range(0, 65535));
            convert(1, v, e);
        end

        @(negedge clk);
        convert(2, 10000, e);
        convert(2, 9999, e);
        convert(2, 65535, e);
        convert(2, 0, e);
        for (int k = 0; k < 6; k++) begin
            v = longint'($urandom_range(0, 65535));
            convert(2, v, e);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
